// File: rtl/ppm16_rx_ctrl_if.sv
// Demodulator control/data and byte-stream output bundle for ppm16_rx_ctrl.
// The master is the controller; the slave is the demod plus the byte consumer.
interface ppm16_rx_ctrl_if #(
  parameter int CHIP_BITS = 2
);
  logic                 demod_resetn;
  logic                 demod_rx_start;
  logic [CHIP_BITS-1:0] demod_corr_threshold;
  logic                 demod_packet_detected;
  logic                 demod_dout_valid;
  logic [3:0]           demod_dout;
  logic [7:0]           m_data;
  logic                 m_valid;
  logic                 m_ready;

  modport master (
    output demod_resetn, demod_rx_start, demod_corr_threshold, m_data, m_valid,
    input  demod_packet_detected, demod_dout_valid, demod_dout, m_ready
  );

  modport slave (
    input  demod_resetn, demod_rx_start, demod_corr_threshold, m_data, m_valid,
    output demod_packet_detected, demod_dout_valid, demod_dout, m_ready
  );
endinterface

// File: rtl/ppm16_rx_ctrl.sv
// ppm16 receive sequencer: arms the demod, retries with lower threshold, packs nibbles into a byte FIFO.
// Output is registered one cycle behind a push; a full FIFO with no pop drops the byte and flags overflow.

module ppm16_rx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  output logic         wr_rdy,
  output logic         rd_vld,
  output logic [W-1:0] rd_dat,
  input  logic         rd_rdy
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [AW:0]   cnt, cnt_nxt;
  logic          push, pop;

  // rd_vld always mirrors cnt != 0, so it doubles as the pop qualifier
  assign pop        = rd_vld & rd_rdy;
  assign wr_rdy     = (cnt != (AW+1)'(DEPTH)) | pop;
  assign push       = wr_vld & wr_rdy;
  assign rd_ptr_nxt = rd_ptr + AW'(pop);
  assign cnt_nxt    = cnt + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      rd_vld <= 1'b0;
      rd_dat <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr_nxt;
      cnt    <= cnt_nxt;
      rd_vld <= (cnt_nxt != '0);
      // the new head is the incoming byte when it lands in the head slot
      if (cnt_nxt != '0)
        rd_dat <= (push && (rd_ptr_nxt == wr_ptr)) ? wr_dat : mem[rd_ptr_nxt];
    end
  end
endmodule

module ppm16_rx_ctrl #(
  parameter int CHIP_BITS  = 2,
  parameter int TW         = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [CHIP_BITS-1:0] cfg_threshold_init,
  input  logic [CHIP_BITS-1:0] cfg_threshold_min,
  input  logic [TW-1:0]        cfg_timeout,
  input  logic [7:0]           cfg_len_bytes,
  ppm16_rx_ctrl_if.master      bus,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output logic                 overflow,
  output logic [CHIP_BITS-1:0] retries
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HOLD   = 3'd1;
  localparam logic [2:0] S_ARM    = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_SEARCH = 3'd4;
  localparam logic [2:0] S_RECV   = 3'd5;

  logic [2:0]           state;
  logic                 en_q;
  logic [CHIP_BITS-1:0] thr, thr_min;
  logic [TW-1:0]        timeout, timer;
  logic [7:0]           len_m1, byte_cnt;
  logic                 phase;
  logic [3:0]           hi_nib;
  logic                 push_vld, push_rdy, expired;
  logic [7:0]           push_dat;

  assign busy                     = (state != S_IDLE);
  assign bus.demod_resetn         = (state == S_ARM) || (state == S_START) ||
                                    (state == S_SEARCH) || (state == S_RECV);
  assign bus.demod_rx_start       = (state == S_START);
  assign bus.demod_corr_threshold = thr;
  assign expired                  = (timer == timeout - TW'(1));

  always_comb begin
    push_vld = (state == S_RECV) && en && bus.demod_dout_valid && phase;
    push_dat = {hi_nib, bus.demod_dout};
  end

  ppm16_rx_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (reset),
    .wr_vld (push_vld),
    .wr_dat (push_dat),
    .wr_rdy (push_rdy),
    .rd_vld (bus.m_valid),
    .rd_dat (bus.m_data),
    .rd_rdy (bus.m_ready)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      en_q        <= 1'b0;
      thr         <= '0;
      thr_min     <= '0;
      timeout     <= '0;
      timer       <= '0;
      len_m1      <= '0;
      byte_cnt    <= '0;
      phase       <= 1'b0;
      hi_nib      <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      overflow    <= 1'b0;
      retries     <= '0;
    end else begin
      en_q <= en;
      done <= 1'b0;
      if (state != S_IDLE && !en) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (en && !en_q) begin
              thr         <= cfg_threshold_init;
              thr_min     <= cfg_threshold_min;
              timeout     <= cfg_timeout;
              len_m1      <= cfg_len_bytes - 8'd1;
              retries     <= '0;
              timeout_err <= 1'b0;
              overflow    <= 1'b0;
              byte_cnt    <= '0;
              phase       <= 1'b0;
              state       <= S_HOLD;
            end
          end
          S_HOLD:  state <= S_ARM;
          S_ARM:   state <= S_START;
          S_START: begin
            timer <= '0;
            state <= S_SEARCH;
          end
          S_SEARCH: begin
            if (bus.demod_packet_detected) begin
              timer <= '0;
              state <= S_RECV;
            end else if (expired) begin
              if (thr > thr_min) begin
                thr     <= thr - CHIP_BITS'(1);
                retries <= retries + CHIP_BITS'(1);
                state   <= S_HOLD;
              end else begin
                timeout_err <= 1'b1;
                state       <= S_IDLE;
              end
            end else begin
              timer <= timer + TW'(1);
            end
          end
          S_RECV: begin
            if (bus.demod_dout_valid) begin
              timer <= '0;
              if (!phase) begin
                hi_nib <= bus.demod_dout;
                phase  <= 1'b1;
              end else begin
                phase    <= 1'b0;
                byte_cnt <= byte_cnt + 8'd1;
                if (!push_rdy) overflow <= 1'b1;
                // len_m1 wraps to 255 when the configured length is 0 (256 bytes)
                if (byte_cnt == len_m1) begin
                  done  <= 1'b1;
                  state <= S_IDLE;
                end
              end
            end else if (expired) begin
              timeout_err <= 1'b1;
              state       <= S_IDLE;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
